conv_window_sequencer: RTL and testbench
========================================

# conv_window_sequencer

Controller that sequences one sliding-window convolution pass of the DCNN accelerator: it steps output-position row/column counters over an N×N input with a K×K filter at stride 1. It drives the window-buffer read port, launches the MAC datapath per output position and waits for it, then issues the output-buffer write. It sits between the layer-level control (START/DONE) and the window buffer, MAC array and output buffer.

## Interface
- CNT_W, 4, width of image/filter size fields and row/column counters (N, K ≤ 2^CNT_W−1)
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset (RST=0 resets)
- START  in  1  begin pass; sampled only in IDLE
- ABORT  in  1  synchronous abort; any non-IDLE state → IDLE next edge
- IMG_N  in  CNT_W  input side length N, latched on accepted START
- FILT_K  in  CNT_W  filter side length K, latched on accepted START
- MAC_DONE  in  1  datapath finished current position; sampled only in WAIT
- RD_EN  out  1  window-buffer read strobe
- RD_ROW  out  CNT_W  image row being read (orow + k)
- RD_COL  out  CNT_W  leftmost image column of window (ocol)
- MAC_START  out  1  one-cycle pulse launching MAC for current window
- WR_EN  out  1  output-buffer write strobe
- WR_ADDR  out  2*CNT_W  output index orow*M + ocol, M = N−K+1
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse at normal pass completion
- ERR  out  1  config error flag; held from DONE pulse until next accepted START

## Operation
- States: IDLE, LOAD, COMPUTE, WAIT, WRITE, FIN.
- IDLE: START=1 → latch N, K; clear orow, ocol, k, ERR. If K=0, N=0 or K>N → FIN with ERR=1 (no reads/writes); else → LOAD.
- LOAD: RD_EN=1, RD_ROW=orow+k, RD_COL=ocol; k increments each cycle; after k=K−1 → COMPUTE, k cleared.
- COMPUTE: MAC_START=1 for one cycle → WAIT.
- WAIT: all strobes low; MAC_DONE=1 at edge → WRITE; otherwise stay (no timeout).
- WRITE: WR_EN=1, WR_ADDR=orow*M+ocol. Then: ocol<M−1 → ocol+1, LOAD; else ocol=0, and orow<M−1 → orow+1, LOAD; else → FIN.
- FIN: DONE=1 for one cycle → IDLE.
- Order is row-major: ocol fastest. Counters never wrap; termination is by compare, not overflow.
- ABORT outranks all transitions except reset; no DONE, ERR unchanged. ABORT in IDLE ignored; ABORT and START together in IDLE: START accepted.
- START outside IDLE ignored. IMG_N/FILT_K changes after latch have no effect.
- MAC_DONE outside WAIT ignored (including during the COMPUTE cycle).
- WR_ADDR product uses latched M computed once at START, full 2*CNT_W width, no truncation.

## Timing
- Reset (RST=0, async): state IDLE, all counters 0, RD_EN=MAC_START=WR_EN=BUSY=DONE=ERR=0, RD_ROW=RD_COL=0, WR_ADDR=0. Reset mid-pass discards the pass; no DONE.
- All outputs registered (Moore); a strobe appears the cycle after the edge entering its state.
- START accepted at edge e0: first RD_EN in cycle 1, K read cycles, MAC_START in cycle K+1, WAIT from cycle K+2.
- MAC_DONE held high: WAIT lasts 1 cycle, WRITE in cycle K+3; each position costs K+3 cycles; pass of M² positions ends with DONE in cycle M²(K+3)+1, BUSY low the cycle after.
- Error config: BUSY and DONE together in cycle 1, ERR=1 from cycle 1.
- Data outputs hold last value when their strobe is low.

## Test plan
- N=4, K=3, MAC_DONE tied high: RD_ROW 0,1,2 col 0, then col 1, rows 1..3 col 0/1; WR_ADDR 0,1,2,3; exactly 4 MAC_START; DONE in cycle 25; ERR=0.
- N=5, K=1, MAC_DONE delayed 3 cycles after each MAC_START: 25 writes, WR_ADDR 0..24 in order, each WR_EN exactly 1 cycle after MAC_DONE edge.
- N=3, K=4 (and separately K=0): no RD_EN/WR_EN/MAC_START; DONE and ERR=1 in cycle 1; next valid START clears ERR.
- START pulsed during LOAD and WAIT, MAC_DONE pulsed during COMPUTE/WRITE: no effect on sequence vs baseline N=4, K=3 trace.
- ABORT during WAIT of position 2: IDLE next edge, BUSY=0, no DONE; new START restarts at WR_ADDR 0.
- RST low mid-LOAD asynchronously (between edges): all outputs 0 immediately; after release, START with N=15, K=15 gives 1 position, 15 reads, WR_ADDR 0, DONE in cycle 19.

Source files
------------

// File: rtl/conv_window_sequencer_if.sv
// Control/data bundle between the convolution window sequencer and the
// layer control, window buffer, MAC array and output buffer.
interface conv_window_sequencer_if #(
    parameter int CNT_W = 4
);
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   imgN;
    logic [CNT_W-1:0]   filtK;
    logic               macDone;
    logic               rdEn;
    logic [CNT_W-1:0]   rdRow;
    logic [CNT_W-1:0]   rdCol;
    logic               macStart;
    logic               wrEn;
    logic [2*CNT_W-1:0] wrAddr;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, abort, imgN, filtK, macDone,
        output rdEn, rdRow, rdCol, macStart, wrEn, wrAddr, busy, done, err
    );

    modport slave (
        output start, abort, imgN, filtK, macDone,
        input  rdEn, rdRow, rdCol, macStart, wrEn, wrAddr, busy, done, err
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Sequences one stride-1 sliding-window convolution pass: window reads,
// MAC launch/wait and output write per output position, row-major.
module conv_window_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    conv_window_sequencer_if.master io_seq
);
    localparam int               ADDR_W = 2 * CNT_W;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_WAIT,
        ST_WRITE,
        ST_FIN
    } seqState_t;

    seqState_t         r_state;
    seqState_t         w_state;
    logic [CNT_W-1:0]  r_filtK;
    logic [CNT_W-1:0]  w_filtK;
    logic [CNT_W-1:0]  r_posM;
    logic [CNT_W-1:0]  w_posM;
    logic [CNT_W-1:0]  r_outRow;
    logic [CNT_W-1:0]  w_outRow;
    logic [CNT_W-1:0]  r_outCol;
    logic [CNT_W-1:0]  w_outCol;
    logic [CNT_W-1:0]  r_kIdx;
    logic [CNT_W-1:0]  w_kIdx;
    logic              r_rdEn;
    logic              w_rdEn;
    logic [CNT_W-1:0]  r_rdRow;
    logic [CNT_W-1:0]  w_rdRow;
    logic [CNT_W-1:0]  r_rdCol;
    logic [CNT_W-1:0]  w_rdCol;
    logic              r_macStart;
    logic              w_macStart;
    logic              r_wrEn;
    logic              w_wrEn;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [ADDR_W-1:0] w_wrAddr;
    logic              r_busy;
    logic              w_busy;
    logic              r_done;
    logic              w_done;
    logic              r_err;
    logic              w_err;

    logic              w_cfgBad;
    logic [CNT_W-1:0]  w_cfgM;
    logic              w_lastK;
    logic              w_lastCol;
    logic              w_lastRow;
    logic [ADDR_W-1:0] w_addrCalc;

    // M is derived once at START so the address math never sees later config changes.
    assign w_cfgBad   = (io_seq.filtK == '0) || (io_seq.imgN == '0) ||
                        (io_seq.filtK > io_seq.imgN);
    assign w_cfgM     = io_seq.imgN - io_seq.filtK + ONE;
    assign w_lastK    = (r_kIdx == r_filtK - ONE);
    assign w_lastCol  = (r_outCol == r_posM - ONE);
    assign w_lastRow  = (r_outRow == r_posM - ONE);
    assign w_addrCalc = ADDR_W'(r_outRow) * ADDR_W'(r_posM) + ADDR_W'(r_outCol);

    always_comb begin
        w_state    = r_state;
        w_filtK    = r_filtK;
        w_posM     = r_posM;
        w_outRow   = r_outRow;
        w_outCol   = r_outCol;
        w_kIdx     = r_kIdx;
        w_rdEn     = 1'b0;
        w_rdRow    = r_rdRow;
        w_rdCol    = r_rdCol;
        w_macStart = 1'b0;
        w_wrEn     = 1'b0;
        w_wrAddr   = r_wrAddr;
        w_done     = 1'b0;
        w_err      = r_err;

        // Outputs are computed for the state being entered, then registered.
        if ((r_state != ST_IDLE) && io_seq.abort) begin
            w_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_seq.start) begin
                        w_filtK  = io_seq.filtK;
                        w_posM   = w_cfgM;
                        w_outRow = '0;
                        w_outCol = '0;
                        w_kIdx   = '0;
                        w_err    = w_cfgBad;
                        if (w_cfgBad) begin
                            w_state = ST_FIN;
                            w_done  = 1'b1;
                        end else begin
                            w_state = ST_LOAD;
                            w_rdEn  = 1'b1;
                            w_rdRow = '0;
                            w_rdCol = '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_lastK) begin
                        w_kIdx     = '0;
                        w_state    = ST_COMPUTE;
                        w_macStart = 1'b1;
                    end else begin
                        w_kIdx  = r_kIdx + ONE;
                        w_rdEn  = 1'b1;
                        w_rdRow = r_outRow + r_kIdx + ONE;
                    end
                end
                ST_COMPUTE: begin
                    w_state = ST_WAIT;
                end
                ST_WAIT: begin
                    if (io_seq.macDone) begin
                        w_state  = ST_WRITE;
                        w_wrEn   = 1'b1;
                        w_wrAddr = w_addrCalc;
                    end
                end
                ST_WRITE: begin
                    if (!w_lastCol) begin
                        w_outCol = r_outCol + ONE;
                        w_state  = ST_LOAD;
                        w_rdEn   = 1'b1;
                        w_rdRow  = r_outRow;
                        w_rdCol  = r_outCol + ONE;
                    end else begin
                        w_outCol = '0;
                        if (!w_lastRow) begin
                            w_outRow = r_outRow + ONE;
                            w_state  = ST_LOAD;
                            w_rdEn   = 1'b1;
                            w_rdRow  = r_outRow + ONE;
                            w_rdCol  = '0;
                        end else begin
                            w_state = ST_FIN;
                            w_done  = 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    w_state = ST_IDLE;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_filtK    <= '0;
            r_posM     <= '0;
            r_outRow   <= '0;
            r_outCol   <= '0;
            r_kIdx     <= '0;
            r_rdEn     <= 1'b0;
            r_rdRow    <= '0;
            r_rdCol    <= '0;
            r_macStart <= 1'b0;
            r_wrEn     <= 1'b0;
            r_wrAddr   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_filtK    <= w_filtK;
            r_posM     <= w_posM;
            r_outRow   <= w_outRow;
            r_outCol   <= w_outCol;
            r_kIdx     <= w_kIdx;
            r_rdEn     <= w_rdEn;
            r_rdRow    <= w_rdRow;
            r_rdCol    <= w_rdCol;
            r_macStart <= w_macStart;
            r_wrEn     <= w_wrEn;
            r_wrAddr   <= w_wrAddr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    assign io_seq.rdEn     = r_rdEn;
    assign io_seq.rdRow    = r_rdRow;
    assign io_seq.rdCol    = r_rdCol;
    assign io_seq.macStart = r_macStart;
    assign io_seq.wrEn     = r_wrEn;
    assign io_seq.wrAddr   = r_wrAddr;
    assign io_seq.busy     = r_busy;
    assign io_seq.done     = r_done;
    assign io_seq.err      = r_err;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed self-checking bench for conv_window_sequencer: hand-computed
// read/write traces, cycle counts, error configs, abort and async reset.
module tb_conv_window_sequencer;
    localparam int CNT_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   vectors     = 0;
    int   miscompares = 0;

    int   rdRowQ[$];
    int   rdColQ[$];
    int   wrQ[$];
    int   expQ[$];
    int   macStartCnt;
    int   doneCount;
    int   doneCycle;
    int   firstMacCycle;
    int   firstWrCycle;
    logic errAtDone;
    logic errCycle1;
    logic busyCycle1;
    bit   timedOut;

    conv_window_sequencer_if #(.CNT_W(CNT_W)) seqIf ();

    conv_window_sequencer #(.CNT_W(CNT_W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_seq (seqIf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    // which: 0 = read rows, 1 = read columns, 2 = write addresses
    task automatic checkQueue(input string name, input int which);
        int actSize;
        int act;
        actSize = (which == 0) ? rdRowQ.size() : (which == 1) ? rdColQ.size() : wrQ.size();
        checkOutput({name, "Count"}, actSize, expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            act = -1;
            if (i < actSize) act = (which == 0) ? rdRowQ[i] : (which == 1) ? rdColQ[i] : wrQ[i];
            checkOutput($sformatf("%s[%0d]", name, i), act, expQ[i]);
        end
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, ".rdEn"},     seqIf.rdEn,     0);
        checkOutput({phase, ".rdRow"},    seqIf.rdRow,    0);
        checkOutput({phase, ".rdCol"},    seqIf.rdCol,    0);
        checkOutput({phase, ".macStart"}, seqIf.macStart, 0);
        checkOutput({phase, ".wrEn"},     seqIf.wrEn,     0);
        checkOutput({phase, ".wrAddr"},   seqIf.wrAddr,   0);
        checkOutput({phase, ".busy"},     seqIf.busy,     0);
        checkOutput({phase, ".done"},     seqIf.done,     0);
        checkOutput({phase, ".err"},      seqIf.err,      0);
    endtask

    task automatic applyStimulus(input int n, input int k, input bit withAbort);
        seqIf.start = 1'b1;
        seqIf.abort = withAbort;
        seqIf.imgN  = CNT_W'(n);
        seqIf.filtK = CNT_W'(k);
        tick();
        seqIf.start = 1'b0;
        seqIf.abort = 1'b0;
    endtask

    // Starts a pass and runs it until DONE or BUSY falls, logging the trace.
    task automatic runPass(input int n, input int k, input int macDelay, input bit disturb,
                           input int abortPos, input bit checkWrTiming);
        int   c;
        int   pending;
        int   abortCycle;
        int   lastMacCycle;
        bit   finished;
        logic prevMacDone;
        rdRowQ.delete();
        rdColQ.delete();
        wrQ.delete();
        macStartCnt   = 0;
        doneCount     = 0;
        doneCycle     = -1;
        firstMacCycle = -1;
        firstWrCycle  = -1;
        errAtDone     = 1'bx;
        pending       = -1;
        abortCycle    = -1;
        lastMacCycle  = -100;
        finished      = 1'b0;
        prevMacDone   = 1'b0;
        seqIf.macDone = (macDelay == 0);
        applyStimulus(n, k, 1'b0);
        c = 1;
        while (!finished && c <= 400) begin
            if (c == 1) begin
                errCycle1  = seqIf.err;
                busyCycle1 = seqIf.busy;
            end
            if (checkWrTiming)
                checkOutput($sformatf("wrEnAfterMacDone@%0d", c), seqIf.wrEn, prevMacDone);
            if (seqIf.rdEn) begin
                rdRowQ.push_back(int'(seqIf.rdRow));
                rdColQ.push_back(int'(seqIf.rdCol));
            end
            if (seqIf.wrEn) begin
                wrQ.push_back(int'(seqIf.wrAddr));
                if (firstWrCycle < 0) firstWrCycle = c;
            end
            if (seqIf.macStart) begin
                macStartCnt++;
                if (firstMacCycle < 0) firstMacCycle = c;
                lastMacCycle = c;
                pending      = c + macDelay;
                if (abortPos == macStartCnt) abortCycle = c + 1;
            end
            if (seqIf.done) begin
                doneCount++;
                doneCycle = c;
                errAtDone = seqIf.err;
                finished  = 1'b1;
            end
            if (!seqIf.busy) finished = 1'b1;

            seqIf.start   = 1'b0;
            seqIf.abort   = (c == abortCycle);
            seqIf.macDone = (macDelay == 0) ? 1'b1 : (c == pending);
            if (disturb) begin
                seqIf.imgN  = '0;
                seqIf.filtK = CNT_W'(7);
                if (seqIf.rdEn || (c == lastMacCycle + 1)) seqIf.start = 1'b1;
                if (seqIf.macStart || seqIf.wrEn) seqIf.macDone = 1'b1;
            end
            prevMacDone = seqIf.macDone;
            if (!finished) begin
                tick();
                c++;
            end
        end
        timedOut      = !finished;
        seqIf.start   = 1'b0;
        seqIf.abort   = 1'b0;
        seqIf.macDone = 1'b0;
        checkOutput($sformatf("passTimeout N=%0d K=%0d", n, k), timedOut, 0);
    endtask

    initial begin
        seqIf.start   = 1'b0;
        seqIf.abort   = 1'b0;
        seqIf.imgN    = '0;
        seqIf.filtK   = '0;
        seqIf.macDone = 1'b0;

        // Reset state
        tick();
        tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        // Baseline N=4, K=3, MAC_DONE tied high
        runPass(4, 3, 0, 1'b0, 0, 1'b0);
        expQ = '{0, 1, 2, 0, 1, 2, 1, 2, 3, 1, 2, 3};
        checkQueue("base.rdRow", 0);
        expQ = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        checkQueue("base.rdCol", 1);
        expQ = '{0, 1, 2, 3};
        checkQueue("base.wrAddr", 2);
        checkOutput("base.macStartCnt", macStartCnt, 4);
        checkOutput("base.firstMacCycle", firstMacCycle, 4);
        checkOutput("base.firstWrCycle", firstWrCycle, 6);
        checkOutput("base.doneCycle", doneCycle, 25);
        checkOutput("base.errAtDone", errAtDone, 0);
        tick();
        checkOutput("base.busyAfter", seqIf.busy, 0);
        checkOutput("base.doneAfter", seqIf.done, 0);

        // N=5, K=1, MAC_DONE three cycles after each MAC_START
        runPass(5, 1, 3, 1'b0, 0, 1'b1);
        expQ.delete();
        for (int i = 0; i < 25; i++) expQ.push_back(i);
        checkQueue("k1.wrAddr", 2);
        expQ.delete();
        for (int i = 0; i < 25; i++) expQ.push_back(i / 5);
        checkQueue("k1.rdRow", 0);
        expQ.delete();
        for (int i = 0; i < 25; i++) expQ.push_back(i % 5);
        checkQueue("k1.rdCol", 1);
        checkOutput("k1.macStartCnt", macStartCnt, 25);
        checkOutput("k1.doneCycle", doneCycle, 151);
        tick();
        checkOutput("k1.busyAfter", seqIf.busy, 0);

        // Error configurations: K > N, then K = 0
        runPass(3, 4, 0, 1'b0, 0, 1'b0);
        checkOutput("kGtN.doneCycle", doneCycle, 1);
        checkOutput("kGtN.busyCycle1", busyCycle1, 1);
        checkOutput("kGtN.errAtDone", errAtDone, 1);
        checkOutput("kGtN.reads", rdRowQ.size(), 0);
        checkOutput("kGtN.writes", wrQ.size(), 0);
        checkOutput("kGtN.macStarts", macStartCnt, 0);
        tick();
        checkOutput("kGtN.busyAfter", seqIf.busy, 0);
        checkOutput("kGtN.doneAfter", seqIf.done, 0);
        checkOutput("kGtN.errHeld", seqIf.err, 1);
        runPass(5, 0, 0, 1'b0, 0, 1'b0);
        checkOutput("k0.doneCycle", doneCycle, 1);
        checkOutput("k0.errAtDone", errAtDone, 1);
        checkOutput("k0.reads", rdRowQ.size(), 0);
        checkOutput("k0.macStarts", macStartCnt, 0);
        tick();

        // Next valid START clears ERR; N=2, K=2 is a single position
        runPass(2, 2, 0, 1'b0, 0, 1'b0);
        checkOutput("clr.errCycle1", errCycle1, 0);
        checkOutput("clr.errAtDone", errAtDone, 0);
        checkOutput("clr.doneCycle", doneCycle, 6);
        expQ = '{0};
        checkQueue("clr.wrAddr", 2);
        tick();

        // ABORT alone in IDLE ignored; ABORT with START accepts START; ABORT in LOAD
        seqIf.abort = 1'b1;
        tick();
        seqIf.abort = 1'b0;
        checkOutput("idleAbort.busy", seqIf.busy, 0);
        applyStimulus(4, 3, 1'b1);
        checkOutput("startAbort.busy", seqIf.busy, 1);
        checkOutput("startAbort.rdEn", seqIf.rdEn, 1);
        checkOutput("startAbort.rdRow", seqIf.rdRow, 0);
        seqIf.abort = 1'b1;
        tick();
        seqIf.abort = 1'b0;
        checkOutput("loadAbort.busy", seqIf.busy, 0);
        checkOutput("loadAbort.rdEn", seqIf.rdEn, 0);
        checkOutput("loadAbort.done", seqIf.done, 0);

        // Stray START / MAC_DONE / config changes leave the N=4, K=3 trace intact
        runPass(4, 3, 3, 1'b1, 0, 1'b0);
        expQ = '{0, 1, 2, 0, 1, 2, 1, 2, 3, 1, 2, 3};
        checkQueue("dist.rdRow", 0);
        expQ = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        checkQueue("dist.rdCol", 1);
        expQ = '{0, 1, 2, 3};
        checkQueue("dist.wrAddr", 2);
        checkOutput("dist.macStartCnt", macStartCnt, 4);
        checkOutput("dist.doneCycle", doneCycle, 33);
        tick();

        // ABORT during WAIT of the second position
        runPass(4, 3, 3, 1'b0, 2, 1'b0);
        expQ = '{0};
        checkQueue("abort.wrAddr", 2);
        checkOutput("abort.doneCount", doneCount, 0);
        checkOutput("abort.busy", seqIf.busy, 0);
        checkOutput("abort.macStartCnt", macStartCnt, 2);
        checkOutput("abort.errHeld", seqIf.err, 0);
        runPass(4, 3, 0, 1'b0, 0, 1'b0);
        expQ = '{0, 1, 2, 3};
        checkQueue("restart.wrAddr", 2);
        checkOutput("restart.doneCycle", doneCycle, 25);
        tick();

        // Asynchronous reset in the middle of LOAD
        applyStimulus(4, 3, 1'b0);
        tick();
        checkOutput("preRst.rdRow", seqIf.rdRow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("asyncRst");
        #2;
        rst_n = 1'b1;
        tick();
        runPass(15, 15, 0, 1'b0, 0, 1'b0);
        expQ.delete();
        for (int i = 0; i < 15; i++) expQ.push_back(i);
        checkQueue("big.rdRow", 0);
        expQ.delete();
        for (int i = 0; i < 15; i++) expQ.push_back(0);
        checkQueue("big.rdCol", 1);
        expQ = '{0};
        checkQueue("big.wrAddr", 2);
        checkOutput("big.macStartCnt", macStartCnt, 1);
        checkOutput("big.doneCycle", doneCycle, 19);
        tick();
        checkOutput("big.busyAfter", seqIf.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
